// File: rtl/sha2_round_unit.sv
// SHA-256 / SHA-512 compression round engine.
// One round per accepted W/K pair, with optional final feed-forward.
module sha2_round_unit #(
  parameter int DATA_W  = 32,
  parameter int ROUNDS  = 64,
  parameter int DELAY_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  ff_en,
  input  logic [DELAY_W-1:0]    delay,
  input  logic [8*DATA_W-1:0]   state_in,
  input  logic [DATA_W-1:0]     w_in,
  input  logic [DATA_W-1:0]     k_in,
  input  logic                  in_valid,
  output logic [8*DATA_W-1:0]   state_out,
  output logic                  out_valid,
  output logic                  done,
  output logic                  busy
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
    $error("sha2_round_unit: DATA_W must be 32 or 64");
  end

  localparam int  CNT_W = $clog2(ROUNDS + 1);
  localparam bit  W64   = (DATA_W == 64);
  localparam int  S0A   = W64 ? 28 : 2;
  localparam int  S0B   = W64 ? 34 : 13;
  localparam int  S0C   = W64 ? 39 : 22;
  localparam int  S1A   = W64 ? 14 : 6;
  localparam int  S1B   = W64 ? 18 : 11;
  localparam int  S1C   = W64 ? 41 : 25;

  typedef enum logic [2:0] {
    IDLE, WAIT, LOAD, ROUND, FINAL, DONE
  } state_t;

  state_t             st_q, st_d;
  logic [DELAY_W-1:0] dly_q;
  logic               ff_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  wk_q [8];
  logic [DATA_W-1:0]  hs_q [8];
  logic [DATA_W-1:0]  in_w [8];
  logic [DATA_W-1:0]  nx_w [8];
  logic [DATA_W-1:0]  sum_w [8];
  logic [DATA_W-1:0]  s0, s1, ch, maj, t1, t2;
  logic [8*DATA_W-1:0] rnd_flat, sum_flat;
  logic               consume, last;

  function automatic logic [DATA_W-1:0] rotr(
    input logic [DATA_W-1:0] x,
    input int                n
  );
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  always_comb begin
    s0  = rotr(wk_q[0], S0A) ^ rotr(wk_q[0], S0B)
        ^ rotr(wk_q[0], S0C);
    s1  = rotr(wk_q[4], S1A) ^ rotr(wk_q[4], S1B)
        ^ rotr(wk_q[4], S1C);
    ch  = (wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]);
    maj = (wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2])
        ^ (wk_q[1] & wk_q[2]);
    t1  = wk_q[7] + s1 + ch + k_in + w_in;
    t2  = s0 + maj;
    nx_w[0] = t1 + t2;
    nx_w[1] = wk_q[0];
    nx_w[2] = wk_q[1];
    nx_w[3] = wk_q[2];
    nx_w[4] = wk_q[3] + t1;
    nx_w[5] = wk_q[4];
    nx_w[6] = wk_q[5];
    nx_w[7] = wk_q[6];
  end

  // word 0 (a) lives in the most significant slice
  always_comb begin
    rnd_flat = '0;
    sum_flat = '0;
    for (int i = 0; i < 8; i++) begin
      in_w[i]  = state_in[(7-i)*DATA_W +: DATA_W];
      sum_w[i] = wk_q[i] + hs_q[i];
      rnd_flat[(7-i)*DATA_W +: DATA_W] = nx_w[i];
      sum_flat[(7-i)*DATA_W +: DATA_W] = sum_w[i];
    end
  end

  assign consume = (st_q == ROUND) && in_valid;
  assign last    = consume
                && (cnt_q == CNT_W'(ROUNDS - 1));
  assign busy    = (st_q != IDLE);

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (run) st_d = (delay != '0) ? WAIT : LOAD;
      end
      WAIT: begin
        if (dly_q == DELAY_W'(1)) st_d = LOAD;
      end
      LOAD:  st_d = ROUND;
      ROUND: begin
        if (last) st_d = ff_q ? FINAL : DONE;
      end
      FINAL: st_d = DONE;
      DONE:  st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= IDLE;
      dly_q     <= '0;
      ff_q      <= 1'b0;
      cnt_q     <= '0;
      state_out <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        wk_q[i] <= '0;
        hs_q[i] <= '0;
      end
    end else begin
      st_q      <= st_d;
      out_valid <= 1'b0;
      // done follows DONE so it never shares a cycle with data
      done      <= (st_q == DONE);
      if (st_q == IDLE && run) begin
        dly_q <= delay;
        ff_q  <= ff_en;
      end
      if (st_q == WAIT) dly_q <= dly_q - DELAY_W'(1);
      if (st_q == LOAD) begin
        cnt_q <= '0;
        for (int i = 0; i < 8; i++) begin
          wk_q[i] <= in_w[i];
          hs_q[i] <= in_w[i];
        end
      end
      if (consume) begin
        cnt_q     <= cnt_q + CNT_W'(1);
        state_out <= rnd_flat;
        out_valid <= 1'b1;
        for (int i = 0; i < 8; i++) wk_q[i] <= nx_w[i];
      end
      if (st_q == FINAL) begin
        state_out <= sum_flat;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha2_round_unit.sv
// Bench for sha2_round_unit: FIPS vectors plus random blocks
// checked against a word-array model of the SHA-2 round.
module tb_sha2_round_unit;

  typedef logic [63:0] word_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         run32 = 1'b0;
  logic         run64 = 1'b0;
  logic         ff_en = 1'b0;
  logic         in_valid = 1'b0;
  logic [7:0]   delay = '0;
  logic [511:0] st_in = '0;
  logic [63:0]  w_drv = '0;
  logic [63:0]  k_drv = '0;
  logic [255:0] so32;
  logic [511:0] so64;
  logic         ov32, ov64, done32, done64, busy32, busy64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sha2_round_unit #(.DATA_W(32), .ROUNDS(64), .DELAY_W(8)) dut32 (
    .clk(clk), .reset(reset), .run(run32), .ff_en(ff_en),
    .delay(delay), .state_in(st_in[255:0]),
    .w_in(w_drv[31:0]), .k_in(k_drv[31:0]),
    .in_valid(in_valid), .state_out(so32),
    .out_valid(ov32), .done(done32), .busy(busy32)
  );

  sha2_round_unit #(.DATA_W(64), .ROUNDS(80), .DELAY_W(8)) dut64 (
    .clk(clk), .reset(reset), .run(run64), .ff_en(ff_en),
    .delay(delay), .state_in(st_in),
    .w_in(w_drv), .k_in(k_drv),
    .in_valid(in_valid), .state_out(so64),
    .out_valid(ov64), .done(done64), .busy(busy64)
  );

  // SHA-256 constants are the top halves of the SHA-512 ones
  word_t K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd,
    64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019,
    64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe,
    64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
    64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
    64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
    64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210,
    64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
    64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
    64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
    64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
    64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910,
    64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
    64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
    64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
    64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9,
    64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207,
    64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
    64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493,
    64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
    64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  word_t IV512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  word_t DIG256 [8] = '{
    64'hba7816bf, 64'h8f01cfea, 64'h414140de, 64'h5dae2223,
    64'hb00361a3, 64'h96177a9c, 64'hb410ff61, 64'hf20015ad
  };

  word_t DIG512 [8] = '{
    64'hddaf35a193617aba, 64'hcc417349ae204131,
    64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
    64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f
  };

  word_t FIRST256 [8] = '{
    64'h5d6aebcd, 64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372,
    64'hfa2a4622, 64'h510e527f, 64'h9b05688c, 64'h1f83d9ab
  };

  word_t cur_iv [8];
  word_t cur_w  [80];
  word_t cur_k  [80];
  word_t ms     [8];
  word_t mh     [8];

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic word_t msk(input int dw);
    return (dw == 64) ? 64'hffff_ffff_ffff_ffff : 64'hffff_ffff;
  endfunction

  function automatic word_t rotr(input word_t x, input int n,
                                 input int dw);
    return ((x >> n) | (x << (dw - n))) & msk(dw);
  endfunction

  function automatic word_t bsig0(input word_t x, input int dw);
    if (dw == 64)
      return rotr(x, 28, dw) ^ rotr(x, 34, dw) ^ rotr(x, 39, dw);
    return rotr(x, 2, dw) ^ rotr(x, 13, dw) ^ rotr(x, 22, dw);
  endfunction

  function automatic word_t bsig1(input word_t x, input int dw);
    if (dw == 64)
      return rotr(x, 14, dw) ^ rotr(x, 18, dw) ^ rotr(x, 41, dw);
    return rotr(x, 6, dw) ^ rotr(x, 11, dw) ^ rotr(x, 25, dw);
  endfunction

  function automatic word_t ssig0(input word_t x, input int dw);
    if (dw == 64) return rotr(x, 1, dw) ^ rotr(x, 8, dw) ^ (x >> 7);
    return rotr(x, 7, dw) ^ rotr(x, 18, dw) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x, input int dw);
    if (dw == 64) return rotr(x, 19, dw) ^ rotr(x, 61, dw) ^ (x >> 6);
    return rotr(x, 17, dw) ^ rotr(x, 19, dw) ^ (x >> 10);
  endfunction

  function automatic logic [511:0] pack8(input word_t a [8],
                                         input int dw);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r = r | (512'(a[i] & msk(dw)) << ((7 - i) * dw));
    return r;
  endfunction

  task automatic model_round(input word_t w, input word_t k,
                             input int dw);
    word_t t1, t2, ch, mj, m;
    m  = msk(dw);
    ch = (ms[4] & ms[5]) ^ (~ms[4] & ms[6]);
    mj = (ms[0] & ms[1]) ^ (ms[0] & ms[2]) ^ (ms[1] & ms[2]);
    t1 = (ms[7] + bsig1(ms[4], dw) + ch + k + w) & m;
    t2 = (bsig0(ms[0], dw) + mj) & m;
    for (int i = 7; i > 0; i--) ms[i] = ms[i-1];
    ms[4] = (ms[4] + t1) & m;
    ms[0] = (t1 + t2) & m;
  endtask

  task automatic load_abc(input int dw, input int nr);
    word_t m;
    m = msk(dw);
    for (int i = 0; i < 8; i++)
      cur_iv[i] = (dw == 64) ? IV512[i] : (IV512[i] >> 32);
    for (int t = 0; t < 16; t++) cur_w[t] = '0;
    cur_w[0]  = (dw == 64) ? 64'h6162638000000000 : 64'h61626380;
    cur_w[15] = 64'd24;
    for (int t = 16; t < nr; t++)
      cur_w[t] = (ssig1(cur_w[t-2], dw) + cur_w[t-7]
                + ssig0(cur_w[t-15], dw) + cur_w[t-16]) & m;
    for (int t = 0; t < nr; t++)
      cur_k[t] = (dw == 64) ? K512[t] : (K512[t] >> 32);
  endtask

  task automatic load_rand(input int dw, input int nr);
    for (int i = 0; i < 8; i++)
      cur_iv[i] = {$urandom, $urandom} & msk(dw);
    for (int t = 0; t < nr; t++) begin
      cur_w[t] = {$urandom, $urandom} & msk(dw);
      cur_k[t] = {$urandom, $urandom} & msk(dw);
    end
  endtask

  task automatic sample(input int dw, output logic [511:0] so,
                        output logic ov, output logic dn,
                        output logic bz);
    if (dw == 64) begin
      so = so64; ov = ov64; dn = done64; bz = busy64;
    end else begin
      so = {256'b0, so32}; ov = ov32; dn = done32; bz = busy32;
    end
  endtask

  // Drives one block and checks every cycle against the model.
  // abort_at > 0 stops driving once that many rounds are consumed.
  task automatic run_block(
    input int dw, input int nr, input logic ff, input int d,
    input int stall_at, input int stall_len,
    input int xrun_at, input int abort_at,
    output logic [511:0] first_out, output logic [511:0] last_out
  );
    int n, idx, stall_left, done_edge, ov_cnt, limit;
    logic consume, fin_pending, exp_ov;
    logic [511:0] so;
    logic ov, dn, bz;
    ms = cur_iv;
    mh = cur_iv;
    first_out = '0;
    last_out  = '0;
    st_in = pack8(cur_iv, dw);
    delay = 8'(d);
    ff_en = ff;
    if (dw == 64) run64 = 1'b1;
    else          run32 = 1'b1;
    @(posedge clk); #1;
    run32 = 1'b0;
    run64 = 1'b0;
    ff_en = ~ff;
    delay = 8'hff;
    n = 1;
    idx = 0;
    stall_left = stall_len;
    done_edge = -1;
    fin_pending = 1'b0;
    ov_cnt = 0;
    limit = d + nr + stall_len + 20;
    while (n < limit) begin
      consume  = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      w_drv    = {$urandom, $urandom};
      k_drv    = {$urandom, $urandom};
      if (n >= d + 2 && idx < nr) begin
        in_valid = 1'b0;
        if (idx == stall_at && stall_left > 0) begin
          stall_left--;
        end else begin
          consume  = 1'b1;
          in_valid = 1'b1;
          w_drv    = cur_w[idx];
          k_drv    = cur_k[idx];
        end
      end
      if (n == xrun_at) begin
        if (dw == 64) run64 = 1'b1;
        else          run32 = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      run32 = 1'b0;
      run64 = 1'b0;
      exp_ov = 1'b0;
      if (consume) begin
        model_round(cur_w[idx], cur_k[idx], dw);
        idx++;
        exp_ov = 1'b1;
        if (idx == nr) begin
          if (ff) fin_pending = 1'b1;
          else    done_edge = n + 1;
        end
      end else if (fin_pending) begin
        for (int i = 0; i < 8; i++)
          ms[i] = (ms[i] + mh[i]) & msk(dw);
        fin_pending = 1'b0;
        exp_ov = 1'b1;
        done_edge = n + 1;
      end
      sample(dw, so, ov, dn, bz);
      chk("out_valid", 512'(ov), 512'(exp_ov));
      if (exp_ov) begin
        chk("state_out", so, pack8(ms, dw));
        ov_cnt++;
        if (ov_cnt == 1) first_out = so;
        last_out = so;
      end
      chk("done", 512'(dn), 512'(n == done_edge));
      chk("busy", 512'(bz),
          512'(done_edge < 0 || n < done_edge));
      if (n == done_edge) break;
      if (abort_at > 0 && idx == abort_at) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic hold_check(input int dw);
    logic [511:0] so;
    logic ov, dn, bz;
    repeat (3) begin
      in_valid = 1'b1;
      w_drv = {$urandom, $urandom};
      @(posedge clk); #1;
      sample(dw, so, ov, dn, bz);
      chk("hold_state", so, pack8(ms, dw));
      chk("hold_ov", 512'(ov), 512'(0));
      chk("hold_done", 512'(dn), 512'(0));
    end
    in_valid = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_so32"}, 512'(so32), 512'(0));
    chk({tag, "_so64"}, so64, 512'(0));
    chk({tag, "_flags"},
        512'({ov32, done32, busy32, ov64, done64, busy64}),
        512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] f, l;
    word_t diff [8];

    reset = 1'b1;
    run32 = 1'b1;
    run64 = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      reset_check("reset");
    end
    reset = 1'b0;
    run32 = 1'b0;
    run64 = 1'b0;
    @(posedge clk); #1;
    reset_check("post_reset");

    load_abc(32, 64);
    run_block(32, 64, 1'b1, 0, -1, 0, -1, 0, f, l);
    chk("abc_first", f, pack8(FIRST256, 32));
    chk("abc_digest", l, pack8(DIG256, 32));
    hold_check(32);

    load_abc(32, 64);
    run_block(32, 64, 1'b1, 0, 10, 3, 30, 0, f, l);
    chk("stall_digest", l, pack8(DIG256, 32));

    load_abc(32, 64);
    run_block(32, 64, 1'b0, 5, -1, 0, -1, 0, f, l);
    for (int i = 0; i < 8; i++)
      diff[i] = (DIG256[i] - cur_iv[i]) & msk(32);
    chk("noff_digest", l, pack8(diff, 32));

    load_abc(32, 64);
    run_block(32, 64, 1'b1, 0, -1, 0, -1, 20, f, l);
    reset = 1'b1;
    in_valid = 1'b1;
    run32 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      reset_check("mid_reset");
    end
    reset = 1'b0;
    in_valid = 1'b0;
    run32 = 1'b0;
    load_abc(32, 64);
    run_block(32, 64, 1'b1, 0, -1, 0, -1, 0, f, l);
    chk("rerun_digest", l, pack8(DIG256, 32));

    repeat (4) begin
      load_rand(32, 64);
      run_block(32, 64, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 6)),
                int'($urandom_range(0, 63)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(5, 40)), 0, f, l);
      hold_check(32);
    end

    load_abc(64, 80);
    run_block(64, 80, 1'b1, 0, -1, 0, -1, 0, f, l);
    chk("sha512_digest", l, pack8(DIG512, 64));
    hold_check(64);

    load_rand(64, 80);
    run_block(64, 80, 1'b0, 3, 40, 2, 20, 0, f, l);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
